uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-byte holding register.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx #(
    parameter int FREQ = 27000000,
    parameter int BAUD = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int CPB = FREQ / BAUD;
    localparam int TW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_rx: FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    sync_reg;
    logic          rx_s;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          fe_reg, fe_next;
    logic          ov_reg, ov_next;
    logic          pe_reg, pe_next;
    logic          armed_reg, armed_next;
    logic          deliver;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_reg, par_bad_next;
`endif

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_reg  <= 2'b11;
            state_reg <= IDLE;
            timer_reg <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            fe_reg    <= 1'b0;
            ov_reg    <= 1'b0;
            pe_reg    <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], uart_rx_i};
            state_reg <= state_next;
            timer_reg <= timer_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            fe_reg    <= fe_next;
            ov_reg    <= ov_next;
            pe_reg    <= pe_next;
            armed_reg <= armed_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) par_bad_reg <= 1'b0;
        else       par_bad_reg <= par_bad_next;
    end
`endif

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        fe_next    = 1'b0;
        ov_next    = 1'b0;
        pe_next    = 1'b0;
        deliver    = 1'b0;
        // A start edge is only honoured once the line has been seen idle (break guard)
        armed_next = rx_s ? 1'b1 : armed_reg;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
`endif
        if (valid_reg && ready_i)
            valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s && armed_reg) begin
                    state_next = START;
                    timer_next = '0;
                end
            end
            START: begin
                if (timer_reg == T_HALF) begin
                    timer_next = '0;
                    idx_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DATA: begin
                if (timer_reg == T_LAST) begin
                    timer_next          = '0;
                    shift_next[idx_reg] = rx_s;
                    idx_next            = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_reg == T_LAST) begin
                    timer_next   = '0;
                    par_bad_next = ^{shift_reg, rx_s};
                    pe_next      = ^{shift_reg, rx_s};
                    state_next   = STOP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (timer_reg == T_LAST) begin
                    timer_next = '0;
                    state_next = IDLE;
                    if (!rx_s) begin
                        fe_next    = 1'b1;
                        armed_next = 1'b0;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        deliver = !par_bad_reg;
`else
                        deliver = 1'b1;
`endif
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Holding register is free if empty or being drained this very cycle
        if (deliver) begin
            if (!valid_reg || ready_i) begin
                data_next  = shift_reg;
                valid_next = 1'b1;
            end else begin
                ov_next = 1'b1;
            end
        end
    end

    assign data_o       = data_reg;
    assign valid_o      = valid_reg;
    assign frame_err_o  = fe_reg;
    assign overrun_o    = ov_reg;
    assign parity_err_o = pe_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CPB=16: table of frames plus hand-written corner sequences.
// Parity checks are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       uart_rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

    uart_rx #(.FREQ(1600000), .BAUD(100000)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .uart_rx_i    (uart_rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         hs_cnt = 0, valid_cyc = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    logic [7:0] hs_data = 8'h00;
    int         n_checks = 0, n_fail = 0;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (valid_o) valid_cyc++;
        if (valid_o && ready_i) begin
            hs_cnt++;
            hs_data = data_o;
        end
        if (frame_err_o)  fe_cnt++;
        if (overrun_o)    ov_cnt++;
        if (parity_err_o) pe_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx_i = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bits(d);
        drive_bit(stop_v);
        uart_rx_i = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_hs;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];
    int   b_hs, b_vc, b_fe, b_ov, b_pe;

    task automatic snap();
        b_hs = hs_cnt; b_vc = valid_cyc; b_fe = fe_cnt; b_ov = ov_cnt; b_pe = pe_cnt;
    endtask

    initial begin
        int   t0, lat;
        logic found;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h55, 1'b0, 0, 1};
        vecs[2] = '{8'h0F, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 0};
        vecs[5] = '{8'h80, 1'b0, 0, 1};

        uart_rx_i = 1'b1;
        ready_i   = 1'b1;
        rst_i     = 1'b1;
        repeat (3) @(posedge clk);
        settle();
        check("reset data_o", data_o, 8'h00);
        check("reset valid_o", valid_o, 0);
        check("reset frame_err_o", frame_err_o, 0);
        check("reset overrun_o", overrun_o, 0);
        check("reset parity_err_o", parity_err_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle(4);

        // Latency: line falls just after edge E0, byte visible after edge E155
        snap();
        t0 = cyc;
        lat = 0;
        found = 1'b0;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (valid_o) begin
                        lat = cyc - t0;
                        found = 1'b1;
                        break;
                    end
                end
            end
        join
        idle(2 * CPB);
        check("latency valid seen", found, 1);
        check("latency cycles", lat, 155);
        check("latency data", hs_data, 8'hC3);
        $display("latency frame data=c3 cycles=%0d", lat);

        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stop);
            idle(2 * CPB);
            $display("vec %0d data=%02h stop=%0b handshakes=%0d frame_err=%0d", i,
                     vecs[i].data, vecs[i].stop, hs_cnt - b_hs, fe_cnt - b_fe);
            check($sformatf("vec%0d handshakes", i), hs_cnt - b_hs, vecs[i].exp_hs);
            check($sformatf("vec%0d valid cycles", i), valid_cyc - b_vc, vecs[i].exp_hs);
            check($sformatf("vec%0d frame_err pulses", i), fe_cnt - b_fe, vecs[i].exp_fe);
            check($sformatf("vec%0d overrun pulses", i), ov_cnt - b_ov, 0);
            check($sformatf("vec%0d parity pulses", i), pe_cnt - b_pe, 0);
            if (vecs[i].exp_hs > 0)
                check($sformatf("vec%0d data", i), hs_data, vecs[i].data);
        end

        // Overrun: consumer stalled across two frames
        snap();
        ready_i = 1'b0;
        send_frame(8'h3C, 1'b1);
        idle(2 * CPB);
        send_frame(8'h81, 1'b1);
        idle(2 * CPB);
        settle();
        $display("overrun seq 3c,81 ready=0 data=%02h valid=%0b overruns=%0d", data_o, valid_o, ov_cnt - b_ov);
        check("ovr overrun pulses", ov_cnt - b_ov, 1);
        check("ovr valid held", valid_o, 1);
        check("ovr data held", data_o, 8'h3C);
        check("ovr no handshake", hs_cnt - b_hs, 0);
        @(posedge clk); #1;
        ready_i = 1'b1;
        settle();
        @(posedge clk); #1;
        settle();
        check("ovr drained handshakes", hs_cnt - b_hs, 1);
        check("ovr drained data", hs_data, 8'h3C);
        check("ovr valid cleared", valid_o, 0);

        // Break: stop bit low and line kept low for three more bit times
        snap();
        send_bits(8'h55);
        uart_rx_i = 1'b0;
        idle(4 * CPB);
        drive_bit(1'b1);
        send_frame(8'h0F, 1'b1);
        idle(2 * CPB);
        $display("break seq 55 then 0f frame_err=%0d handshakes=%0d", fe_cnt - b_fe, hs_cnt - b_hs);
        check("brk frame_err pulses", fe_cnt - b_fe, 1);
        check("brk handshakes", hs_cnt - b_hs, 1);
        check("brk data", hs_data, 8'h0F);

        // Glitch: four low cycles while idle, then a clean frame
        snap();
        uart_rx_i = 1'b0;
        idle(4);
        uart_rx_i = 1'b1;
        idle(3 * CPB);
        check("glitch valid cycles", valid_cyc - b_vc, 0);
        check("glitch frame_err", fe_cnt - b_fe, 0);
        send_frame(8'h5A, 1'b1);
        idle(2 * CPB);
        $display("glitch seq then 5a handshakes=%0d", hs_cnt - b_hs);
        check("glitch next handshakes", hs_cnt - b_hs, 1);
        check("glitch next data", hs_data, 8'h5A);

        // Reset pulse in the middle of bit 3 of 8'hFF
        snap();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        uart_rx_i = 1'b1;
        idle(8);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        settle();
        check("rst data cleared", data_o, 8'h00);
        idle(7);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        idle(2 * CPB);
        check("rst frame dropped", hs_cnt - b_hs, 0);
        check("rst no frame_err", fe_cnt - b_fe, 0);
        send_frame(8'h12, 1'b1);
        idle(2 * CPB);
        $display("reset seq ff aborted then 12 handshakes=%0d data=%02h", hs_cnt - b_hs, hs_data);
        check("rst next handshakes", hs_cnt - b_hs, 1);
        check("rst next data", hs_data, 8'h12);

`ifdef UART_RX_PARITY_EN
        snap();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(2 * CPB);
        check("par bad pulses", pe_cnt - b_pe, 1);
        check("par bad handshakes", hs_cnt - b_hs, 0);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(2 * CPB);
        $display("parity seq 07 bad then good parity_err=%0d handshakes=%0d", pe_cnt - b_pe, hs_cnt - b_hs);
        check("par good pulses", pe_cnt - b_pe, 1);
        check("par good handshakes", hs_cnt - b_hs, 1);
        check("par good data", hs_data, 8'h07);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
